// File: rtl/tilt_decoder.sv
// Tilt sample classifier plus debounce FSM producing the registered 2-bit rotate direction.
// Optional hysteresis on the published direction is enabled by defining TILT_HYSTERESIS_EN.
module tilt_decoder #(
  parameter int THRESH   = 4000,
  parameter int HYST     = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid_in,
  input  logic signed [15:0] ax_in,
  input  logic signed [15:0] ay_in,
  output logic [1:0]         rotate_out,
  output logic               changed_out
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_LEVEL = 2'b11
  } dir_t;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CAND   = 1'b1
  } state_t;

  localparam logic signed [16:0] TH_POS = 17'(THRESH);
  localparam logic signed [16:0] TH_NEG = 17'(-THRESH);
  localparam logic [7:0]         DEB    = 8'(DEBOUNCE);

  if (DEBOUNCE < 1 || DEBOUNCE > 255 || HYST < 0 || HYST > THRESH) begin : g_param_err
    $error("tilt_decoder: parameter out of range");
  end

  logic signed [16:0] ax_s;
  logic signed [16:0] ay_s;
  dir_t               cls_raw_d, cls_raw_q;
  logic               cls_vld_q;
  dir_t               cls_s;

  assign ax_s = {ax_in[15], ax_in};
  assign ay_s = {ay_in[15], ay_in};

  // Plain-threshold classification in priority order up, down, left, level.
  always_comb begin
    cls_raw_d = DIR_LEVEL;
    if (ay_s >= TH_POS) begin
      cls_raw_d = DIR_UP;
    end else if (ay_s <= TH_NEG) begin
      cls_raw_d = DIR_DOWN;
    end else if (ax_s <= TH_NEG) begin
      cls_raw_d = DIR_LEFT;
    end else begin
      cls_raw_d = DIR_LEVEL;
    end
  end

  dir_t   stable_q, stable_d;
  dir_t   cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  state_t state_q, state_d;
  logic [1:0] rotate_q;
  logic       changed_q;

`ifdef TILT_HYSTERESIS_EN
  localparam logic signed [16:0] HOLD_POS = 17'(THRESH - HYST);
  localparam logic signed [16:0] HOLD_NEG = 17'(HYST - THRESH);

  logic hold_up_q, hold_dn_q, hold_lf_q;

  // Hold flags are captured with the sample and resolved later against the live published
  // direction, so back-to-back samples always see every earlier commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_up_q <= 1'b0;
      hold_dn_q <= 1'b0;
      hold_lf_q <= 1'b0;
    end else if (sample_valid_in) begin
      hold_up_q <= (ay_s >= HOLD_POS);
      hold_dn_q <= (ay_s <= HOLD_NEG);
      hold_lf_q <= (ax_s <= HOLD_NEG);
    end
  end

  always_comb begin
    cls_s = cls_raw_q;
    if (stable_q == DIR_UP && hold_up_q) begin
      cls_s = DIR_UP;
    end else if (stable_q == DIR_DOWN && hold_dn_q) begin
      cls_s = DIR_DOWN;
    end else if (stable_q == DIR_LEFT && hold_lf_q) begin
      cls_s = DIR_LEFT;
    end else begin
      cls_s = cls_raw_q;
    end
  end
`else
  assign cls_s = cls_raw_q;
`endif

  // Stage 1 register: raw class and its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_raw_q <= DIR_LEVEL;
      cls_vld_q <= 1'b0;
    end else begin
      cls_vld_q <= sample_valid_in;
      if (sample_valid_in) begin
        cls_raw_q <= cls_raw_d;
      end
    end
  end

  // Debounce next-state logic; only class-valid cycles move the state.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (cls_vld_q) begin
      case (state_q)
        ST_STABLE: begin
          if (cls_s == stable_q) begin
            cnt_d = 8'd0;
          end else if (DEB == 8'd1) begin
            stable_d = cls_s;
            cand_d   = cls_s;
            cnt_d    = 8'd0;
          end else begin
            cand_d  = cls_s;
            cnt_d   = 8'd1;
            state_d = ST_CAND;
          end
        end
        ST_CAND: begin
          if (cls_s == stable_q) begin
            cnt_d   = 8'd0;
            state_d = ST_STABLE;
          end else if (cls_s != cand_q) begin
            cand_d = cls_s;
            cnt_d  = 8'd1;
          end else if (cnt_q >= DEB - 8'd1) begin
            stable_d = cand_q;
            cnt_d    = 8'd0;
            state_d  = ST_STABLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          cnt_d   = 8'd0;
          state_d = ST_STABLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STABLE;
      cand_q   <= DIR_LEVEL;
      cnt_q    <= 8'd0;
      stable_q <= DIR_LEVEL;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Output stage: a commit shows one cycle after it is decided, with a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rotate_q  <= 2'b11;
      changed_q <= 1'b0;
    end else begin
      rotate_q  <= stable_q;
      changed_q <= (stable_q != dir_t'(rotate_q));
    end
  end

  assign rotate_out  = rotate_q;
  assign changed_out = changed_q;

endmodule

// File: tb/tb_tilt_decoder.sv
// Randomized and directed bench for tilt_decoder, checked cycle by cycle against a sample-level model.
module tb_tilt_decoder;

  localparam int TH  = 4000;
  localparam int HY  = 1000;
  localparam int DEB = 4;

  logic               clk;
  logic               rst;
  logic               sample_valid_in;
  logic signed [15:0] ax_in;
  logic signed [15:0] ay_in;
  logic [1:0]         rotate_out;
  logic               changed_out;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic [1:0] m_pub, m_cand;
  int         m_run;
  logic [1:0] p1_r, p2_r;
  logic       p1_c, p2_c;

  tilt_decoder #(.THRESH(TH), .HYST(HY), .DEBOUNCE(DEB)) dut (
    .clk             (clk),
    .rst             (rst),
    .sample_valid_in (sample_valid_in),
    .ax_in           (ax_in),
    .ay_in           (ay_in),
    .rotate_out      (rotate_out),
    .changed_out     (changed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] classify(input int ax, input int ay, input logic [1:0] pub);
`ifdef TILT_HYSTERESIS_EN
    if (pub == 2'b00 && ay >= TH - HY) return 2'b00;
    if (pub == 2'b01 && ay <= -(TH - HY)) return 2'b01;
    if (pub == 2'b10 && ax <= -(TH - HY)) return 2'b10;
`endif
    if (ay >= TH) return 2'b00;
    if (ay <= -TH) return 2'b01;
    if (ax <= -TH) return 2'b10;
    return 2'b11;
  endfunction

  task automatic model_reset();
    m_pub  = 2'b11;
    m_cand = 2'b11;
    m_run  = 0;
    p1_r   = 2'b11;
    p2_r   = 2'b11;
    p1_c   = 1'b0;
    p2_c   = 1'b0;
  endtask

  // One clock: drive a sample, check outputs against the model's state from two samples-edges ago.
  task automatic step(input bit v, input int ax, input int ay);
    logic [1:0] c;
    logic       commit;
    sample_valid_in = v;
    ax_in = 16'(ax);
    ay_in = 16'(ay);
    @(posedge clk);
    #1;
    checks++;
    if (rotate_out !== p2_r || changed_out !== p2_c) begin
      errors++;
      $display("FAIL cycle_check t=%0t rotate=%b changed=%b required rotate=%b changed=%b",
               $time, rotate_out, changed_out, p2_r, p2_c);
    end
    if (changed_out === 1'b1) pulses++;
    commit = 1'b0;
    if (v) begin
      c = classify(int'(ax_in), int'(ay_in), m_pub);
      if (c == m_pub) begin
        m_run = 0;
      end else if (m_run > 0 && c == m_cand) begin
        m_run++;
      end else begin
        m_cand = c;
        m_run  = 1;
      end
      if (m_run >= DEB) begin
        m_pub  = m_cand;
        m_run  = 0;
        commit = 1'b1;
      end
    end
    p2_r = p1_r;
    p2_c = p1_c;
    p1_r = m_pub;
    p1_c = commit;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rotate_out !== 2'b11 || changed_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset rotate=%b changed=%b required rotate=11 changed=0", rotate_out, changed_out);
    end
    @(negedge clk);
    rst = 1'b0;
    sample_valid_in = 1'b0;
    model_reset();
  endtask

  task automatic expect_state(input string name, input logic [1:0] r, input int npulse);
    checks++;
    if (rotate_out !== r || pulses != npulse) begin
      errors++;
      $display("FAIL %s rotate=%b pulses=%0d required rotate=%b pulses=%0d", name, rotate_out, pulses, r, npulse);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_valid_in = 1'b0;
    ax_in = 16'sd0;
    ay_in = 16'sd0;
    model_reset();
    #12;
    expect_state("reset_value", 2'b11, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    expect_state("reset_no_samples", 2'b11, 0);
  endtask

  task automatic test_up_down();
    pulses = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 0, 5000);
    expect_state("up_not_yet", 2'b11, 0);
    idle(2);
    expect_state("up_commit", 2'b00, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 0, -5000);
    idle(3);
    expect_state("down_commit", 2'b01, 2);
    do_reset();
  endtask

  task automatic test_bounce();
    int seq [7] = '{5000, 5000, 5000, 0, 5000, 5000, 5000};
    pulses = 0;
    foreach (seq[i]) step(1'b1, 0, seq[i]);
    idle(3);
    expect_state("bounce_reject", 2'b11, 0);
    step(1'b1, 0, 5000);
    idle(2);
    expect_state("bounce_then_up", 2'b00, 1);
    do_reset();
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 4; i++) step(1'b1, 0, 5000);
    idle(2);
    for (int i = 0; i < 10; i++) step(1'b1, 0, 3500);
    idle(2);
    checks++;
`ifdef TILT_HYSTERESIS_EN
    if (rotate_out !== 2'b00) begin
      errors++;
      $display("FAIL hysteresis_hold rotate=%b required 00", rotate_out);
    end
`else
    if (rotate_out !== 2'b11) begin
      errors++;
      $display("FAIL no_hysteresis_level rotate=%b required 11", rotate_out);
    end
`endif
    do_reset();
  endtask

  task automatic test_extremes();
    pulses = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 0, -32768);
    idle(2);
    expect_state("min_down", 2'b01, 1);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) step(1'b1, -6000, 6000);
    idle(2);
    expect_state("up_beats_left", 2'b00, 1);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) step(1'b1, -32768, 3999);
    idle(2);
    expect_state("left_below_thresh", 2'b10, 1);
    do_reset();
  endtask

  task automatic test_gapped();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 0, 5000);
      idle($urandom_range(0, 20));
    end
    idle(2);
    expect_state("gapped_commit", 2'b00, 1);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, 5000);
      idle($urandom_range(0, 20));
    end
    do_reset();
    step(1'b1, 0, 5000);
    idle(4);
    expect_state("gapped_reset_no_commit", 2'b11, 0);
  endtask

  task automatic test_random();
    int vals [8] = '{5000, -5000, 3500, -3500, 0, 3000, -32768, 32767};
    int ax, ay, run;
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      ax  = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 65535) - 32768) : vals[$urandom_range(0, 7)];
      ay  = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 65535) - 32768) : vals[$urandom_range(0, 7)];
      run = $urandom_range(1, 7);
      for (int j = 0; j < run; j++) step(($urandom_range(0, 3) != 0), ax, ay);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_up_down();
    test_bounce();
    test_hysteresis();
    test_extremes();
    test_gapped();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
